// File: rtl/i2c_dac_pkg.sv
// Shared types and constants for the I2C DAC target (MCP4725 fast-write emulation).
package i2c_dac_pkg;

  localparam int unsigned CODE_W    = 12;
  localparam int unsigned PD_W      = 2;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned ADDR_W    = 7;

  localparam logic [1:0]        CMD_FAST         = 2'b00;
  localparam logic [ADDR_W-1:0] DEV_ADDR_DEFAULT = 7'h60;

  // Read-back layout: byte 0 = {cmd, pd, code[11:8]}, byte 1 = code[7:0]
  localparam int unsigned RD_HI_NIB_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } state_e;

  function automatic logic [BYTE_W-1:0] rd_byte(
    input logic              sel_lo,
    input logic [PD_W-1:0]   pd,
    input logic [CODE_W-1:0] code
  );
    if (sel_lo) rd_byte = code[BYTE_W-1:0];
    else        rd_byte = {CMD_FAST, pd, code[CODE_W-1:CODE_W-RD_HI_NIB_W]};
  endfunction

endpackage

// File: rtl/i2c_dac_target_line_sync.sv
// SCL/SDA synchronizers with one-cycle scl edge and START/STOP strobes.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda_c,
  output logic o_scl_rise_c,
  output logic o_scl_fall_c,
  output logic o_start_c,
  output logic o_stop_c
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  // Idle bus is high, so everything resets to 1 to avoid false edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  assign o_sda_c      = w_sda;
  assign o_scl_rise_c = ~r_scl_prev & w_scl;
  assign o_scl_fall_c = r_scl_prev & ~w_scl;
  assign o_start_c    = r_sda_prev & ~w_sda & r_scl_prev & w_scl;
  assign o_stop_c     = ~r_sda_prev & w_sda & r_scl_prev & w_scl;

endmodule

// File: rtl/i2c_dac_target.sv
// I2C target emulating a 12-bit MCP4725-style DAC: fast-write decode and code read-back.
module i2c_dac_target
  import i2c_dac_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              i2c_scl_in,
  input  logic              i2c_sda_in,
  output logic              i2c_scl_oe,
  output logic              i2c_sda_oe,
  output logic [CODE_W-1:0] dac_code,
  output logic [PD_W-1:0]   dac_pd,
  output logic              dac_valid,
  output logic              busy
);

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk          (clk_clk),
    .rst          (reset_reset),
    .i_scl        (i2c_scl_in),
    .i_sda        (i2c_sda_in),
    .o_sda_c      (w_sda),
    .o_scl_rise_c (w_scl_rise),
    .o_scl_fall_c (w_scl_fall),
    .o_start_c    (w_start),
    .o_stop_c     (w_stop)
  );

  state_e                 r_state,     w_state_nxt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt,   w_bit_cnt_nxt;
  logic [BYTE_W-2:0]      r_shift,     w_shift_nxt;
  logic [BYTE_W-1:0]      r_tx,        w_tx_nxt;
  logic                   r_byte_idx,  w_byte_idx_nxt;
  logic                   r_rw,        w_rw_nxt;
  logic                   r_ack_phase, w_ack_phase_nxt;
  logic [PD_W-1:0]        r_pd_lat,    w_pd_lat_nxt;
  logic [RD_HI_NIB_W-1:0] r_hi_lat,    w_hi_lat_nxt;
  logic [PD_W-1:0]        r_snap_pd,   w_snap_pd_nxt;
  logic [CODE_W-1:0]      r_snap_code, w_snap_code_nxt;
  logic                   r_sda_oe,    w_sda_oe_nxt;
  logic [CODE_W-1:0]      r_dac_code,  w_dac_code_nxt;
  logic [PD_W-1:0]        r_dac_pd,    w_dac_pd_nxt;
  logic                   r_dac_valid, w_dac_valid_nxt;
  logic                   r_busy,      w_busy_nxt;

  logic [BYTE_W-1:0] w_byte_in;
  logic [BYTE_W-1:0] w_rd_first;
  logic [BYTE_W-1:0] w_rd_next;

  assign w_byte_in  = {r_shift, w_sda};
  assign w_rd_first = rd_byte(1'b0, r_dac_pd, r_dac_code);
  assign w_rd_next  = rd_byte(~r_byte_idx, r_snap_pd, r_snap_code);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
      r_byte_idx  <= 1'b0;
      r_rw        <= 1'b0;
      r_ack_phase <= 1'b0;
      r_pd_lat    <= '0;
      r_hi_lat    <= '0;
      r_snap_pd   <= '0;
      r_snap_code <= '0;
      r_sda_oe    <= 1'b0;
      r_dac_code  <= '0;
      r_dac_pd    <= '0;
      r_dac_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_tx        <= w_tx_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_rw        <= w_rw_nxt;
      r_ack_phase <= w_ack_phase_nxt;
      r_pd_lat    <= w_pd_lat_nxt;
      r_hi_lat    <= w_hi_lat_nxt;
      r_snap_pd   <= w_snap_pd_nxt;
      r_snap_code <= w_snap_code_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_dac_code  <= w_dac_code_nxt;
      r_dac_pd    <= w_dac_pd_nxt;
      r_dac_valid <= w_dac_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state and datapath; SDA drive only ever changes on an scl_fall strobe
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_tx_nxt        = r_tx;
    w_byte_idx_nxt  = r_byte_idx;
    w_rw_nxt        = r_rw;
    w_ack_phase_nxt = r_ack_phase;
    w_pd_lat_nxt    = r_pd_lat;
    w_hi_lat_nxt    = r_hi_lat;
    w_snap_pd_nxt   = r_snap_pd;
    w_snap_code_nxt = r_snap_code;
    w_sda_oe_nxt    = r_sda_oe;
    w_dac_code_nxt  = r_dac_code;
    w_dac_pd_nxt    = r_dac_pd;
    w_dac_valid_nxt = 1'b0;

    if (w_start) begin
      w_state_nxt     = ST_ADDR;
      w_bit_cnt_nxt   = '0;
      w_byte_idx_nxt  = 1'b0;
      w_ack_phase_nxt = 1'b0;
      w_sda_oe_nxt    = 1'b0;
    end else if (w_stop) begin
      w_state_nxt     = ST_IDLE;
      w_bit_cnt_nxt   = '0;
      w_ack_phase_nxt = 1'b0;
      w_sda_oe_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_IGNORE: begin
        end

        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte_in[BYTE_W-2:0];
            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
            if (r_bit_cnt == BIT_CNT_W'(7)) begin
              if (w_byte_in[BYTE_W-1:1] == DEV_ADDR) begin
                w_state_nxt     = ST_ADDR_ACK;
                w_rw_nxt        = w_byte_in[0];
                w_ack_phase_nxt = 1'b0;
              end else begin
                w_state_nxt = ST_IGNORE;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_phase) begin
              w_sda_oe_nxt    = 1'b1;
              w_ack_phase_nxt = 1'b1;
            end else begin
              w_ack_phase_nxt = 1'b0;
              w_byte_idx_nxt  = 1'b0;
              if (r_rw) begin
                // Freeze the readback value so both bytes come from one code
                w_snap_pd_nxt   = r_dac_pd;
                w_snap_code_nxt = r_dac_code;
                w_sda_oe_nxt    = ~w_rd_first[BYTE_W-1];
                w_tx_nxt        = {w_rd_first[BYTE_W-2:0], 1'b0};
                w_bit_cnt_nxt   = BIT_CNT_W'(1);
                w_state_nxt     = ST_RD_BYTE;
              end else begin
                w_sda_oe_nxt  = 1'b0;
                w_bit_cnt_nxt = '0;
                w_state_nxt   = ST_WR_BYTE;
              end
            end
          end
        end

        ST_WR_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte_in[BYTE_W-2:0];
            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
            if (r_bit_cnt == BIT_CNT_W'(7)) begin
              w_ack_phase_nxt = 1'b0;
              if (!r_byte_idx) begin
                if (w_byte_in[7:6] == CMD_FAST) begin
                  w_pd_lat_nxt = w_byte_in[5:4];
                  w_hi_lat_nxt = w_byte_in[3:0];
                  w_state_nxt  = ST_WR_ACK;
                end else begin
                  w_state_nxt = ST_IGNORE;
                end
              end else begin
                w_dac_code_nxt  = {r_hi_lat, w_byte_in};
                w_dac_pd_nxt    = r_pd_lat;
                w_dac_valid_nxt = 1'b1;
                w_state_nxt     = ST_WR_ACK;
              end
            end
          end
        end

        ST_WR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_phase) begin
              w_sda_oe_nxt    = 1'b1;
              w_ack_phase_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt    = 1'b0;
              w_ack_phase_nxt = 1'b0;
              w_byte_idx_nxt  = ~r_byte_idx;
              w_bit_cnt_nxt   = '0;
              w_state_nxt     = ST_WR_BYTE;
            end
          end
        end

        ST_RD_BYTE: begin
          // bit_cnt counts bits already driven; wrap to 0 means all 8 are out
          if (w_scl_fall) begin
            if (r_bit_cnt == '0) begin
              w_sda_oe_nxt    = 1'b0;
              w_ack_phase_nxt = 1'b0;
              w_state_nxt     = ST_RD_ACK;
            end else begin
              w_sda_oe_nxt  = ~r_tx[BYTE_W-1];
              w_tx_nxt      = {r_tx[BYTE_W-2:0], 1'b0};
              w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
            end
          end
        end

        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) w_state_nxt = ST_IGNORE;
            else       w_ack_phase_nxt = 1'b1;
          end else if (w_scl_fall && r_ack_phase) begin
            w_ack_phase_nxt = 1'b0;
            w_byte_idx_nxt  = ~r_byte_idx;
            w_sda_oe_nxt    = ~w_rd_next[BYTE_W-1];
            w_tx_nxt        = {w_rd_next[BYTE_W-2:0], 1'b0};
            w_bit_cnt_nxt   = BIT_CNT_W'(1);
            w_state_nxt     = ST_RD_BYTE;
          end
        end

        default: w_state_nxt = ST_IDLE;
      endcase
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign i2c_scl_oe = 1'b0;
  assign i2c_sda_oe = r_sda_oe;
  assign dac_code   = r_dac_code;
  assign dac_pd     = r_dac_pd;
  assign dac_valid  = r_dac_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_dac_target.sv
// Bit-banged I2C master driving i2c_dac_target with a scoreboard of DAC updates and read bytes.
`timescale 1ns/1ps
module tb_i2c_dac_target;

  localparam int Q = 625;

  typedef struct packed {
    logic [1:0]  pd;
    logic [11:0] code;
  } dac_upd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        scl_line;
  logic        sda_line;
  logic        scl_oe;
  logic        sda_oe;
  logic [11:0] dac_code;
  logic [1:0]  dac_pd;
  logic        dac_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic ack_win = 1'b0;
  logic rd_mode = 1'b0;
  int   oe_viol = 0;
  int   oe_cycles = 0;
  int   valid_cnt = 0;

  dac_upd_t    q_exp[$];
  dac_upd_t    q_obs[$];
  logic [7:0]  q_rd_exp[$];
  dac_upd_t    obs_u;

  always #10 clk = ~clk;

  assign scl_line = m_scl & ~scl_oe;
  assign sda_line = m_sda & ~sda_oe;

  i2c_dac_target #(
    .DEV_ADDR    (7'h60),
    .SYNC_STAGES (2)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .i2c_scl_in  (scl_line),
    .i2c_sda_in  (sda_line),
    .i2c_scl_oe  (scl_oe),
    .i2c_sda_oe  (sda_oe),
    .dac_code    (dac_code),
    .dac_pd      (dac_pd),
    .dac_valid   (dac_valid),
    .busy        (busy)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (sda_oe) begin
        oe_cycles++;
        if (!ack_win && !rd_mode) oe_viol++;
      end
      if (dac_valid) begin
        valid_cnt++;
        obs_u.pd   = dac_pd;
        obs_u.code = dac_code;
        q_obs.push_back(obs_u);
      end
    end
  end

  task automatic i2c_start;
    m_sda = 1'b1; #(Q);
    m_scl = 1'b1; #(Q);
    m_sda = 1'b0; #(Q);
    m_scl = 1'b0; #(Q);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; #(Q);
    m_scl = 1'b1; #(Q);
    m_sda = 1'b1; #(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; #(Q);
      m_scl = 1'b1; #(2*Q);
      m_scl = 1'b0;
      if (i == 0) ack_win = 1'b1;
      #(Q);
    end
    m_sda = 1'b1; #(Q);
    m_scl = 1'b1; #(Q);
    ack = sda_line; #(Q);
    m_scl = 1'b0; #(Q);
    ack_win = 1'b0;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #(Q);
      m_scl = 1'b1; #(Q);
      b[i] = sda_line; #(Q);
      m_scl = 1'b0;
    end
    m_sda = mack; #(Q);
    m_scl = 1'b1; #(2*Q);
    m_scl = 1'b0; #(Q);
    m_sda = 1'b1;
  endtask

  task automatic settle;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (sda_oe !== 1'b0 || scl_oe !== 1'b0) begin
      failures++; $display("FAIL reset_oe: got sda_oe=%b scl_oe=%b expected 0 0", sda_oe, scl_oe);
    end
    checks++;
    if (dac_code !== 12'h000 || dac_pd !== 2'b00) begin
      failures++; $display("FAIL reset_dac: got code=%h pd=%h expected 000 0", dac_code, dac_pd);
    end
    checks++;
    if (dac_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got valid=%b busy=%b expected 0 0", dac_valid, busy);
    end
    rst = 1'b0;
    settle();
  endtask

  task automatic test_single_write;
    logic a0, a1, a2;
    int   viol0, val0;
    viol0 = oe_viol; val0 = valid_cnt;
    i2c_start();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_start: got %b expected 1", busy); end
    write_byte(8'hC0, a0);
    write_byte(8'h0A, a1);
    q_exp.push_back('{pd: 2'd0, code: 12'hABC});
    write_byte(8'hBC, a2);
    i2c_stop();
    settle();
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL single_acks: got %b expected 000", {a0, a1, a2}); end
    checks++;
    if (valid_cnt - val0 != 1) begin failures++; $display("FAIL single_valid_cnt: got %0d expected 1", valid_cnt - val0); end
    checks++;
    if (oe_viol != viol0) begin failures++; $display("FAIL single_oe_outside_ack: got %0d cycles expected 0", oe_viol - viol0); end
    checks++;
    if (q_obs.size() != q_exp.size()) begin
      failures++; $display("FAIL single_sb_size: got %0d expected %0d", q_obs.size(), q_exp.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      dac_upd_t o, e;
      o = q_obs.pop_front(); e = q_exp.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL single_sb_update: got pd=%h code=%h expected pd=%h code=%h", o.pd, o.code, e.pd, e.code); end
    end
    q_obs.delete(); q_exp.delete();
    checks++;
    if (busy !== 1'b0 || dac_code !== 12'hABC) begin
      failures++; $display("FAIL single_end_state: got busy=%b code=%h expected 0 abc", busy, dac_code);
    end
  endtask

  task automatic test_addr_mismatch;
    logic a0, a1, a2;
    int   oe0, val0;
    oe0 = oe_cycles; val0 = valid_cnt;
    i2c_start();
    write_byte(8'h62, a0);
    write_byte(8'h0F, a1);
    write_byte(8'hFF, a2);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mismatch_busy_during: got %b expected 1", busy); end
    i2c_stop();
    settle();
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL mismatch_acks: got %b expected 111", {a0, a1, a2}); end
    checks++;
    if (oe_cycles != oe0) begin failures++; $display("FAIL mismatch_sda_driven: got %0d cycles expected 0", oe_cycles - oe0); end
    checks++;
    if (valid_cnt != val0 || dac_code !== 12'hABC) begin
      failures++; $display("FAIL mismatch_no_update: got valid=%0d code=%h expected 0 abc", valid_cnt - val0, dac_code);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mismatch_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_bad_cmd;
    logic a0, a1;
    int   val0, viol0;
    val0 = valid_cnt; viol0 = oe_viol;
    i2c_start();
    write_byte(8'hC0, a0);
    write_byte(8'h41, a1);
    i2c_stop();
    settle();
    checks++;
    if ({a0, a1} !== 2'b01) begin failures++; $display("FAIL badcmd_acks: got %b expected 01", {a0, a1}); end
    checks++;
    if (valid_cnt != val0 || dac_code !== 12'hABC || dac_pd !== 2'd0) begin
      failures++; $display("FAIL badcmd_no_update: got valid=%0d code=%h pd=%h expected 0 abc 0", valid_cnt - val0, dac_code, dac_pd);
    end
    checks++;
    if (oe_viol != viol0) begin failures++; $display("FAIL badcmd_oe_outside_ack: got %0d expected 0", oe_viol - viol0); end
  endtask

  task automatic test_read;
    logic       a0, a1, a2;
    logic [7:0] b;
    i2c_start();
    write_byte(8'hC0, a0);
    write_byte(8'h2A, a1);
    q_exp.push_back('{pd: 2'd2, code: 12'hABC});
    write_byte(8'hBC, a2);
    i2c_stop();
    settle();
    checks++;
    if (q_obs.size() != 1) begin
      failures++; $display("FAIL read_setup_sb_size: got %0d expected 1", q_obs.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      dac_upd_t o, e;
      o = q_obs.pop_front(); e = q_exp.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL read_setup_update: got pd=%h code=%h expected pd=%h code=%h", o.pd, o.code, e.pd, e.code); end
    end
    q_obs.delete(); q_exp.delete();
    rd_mode = 1'b1;
    i2c_start();
    write_byte(8'hC1, a0);
    checks++;
    if (a0 !== 1'b0) begin failures++; $display("FAIL read_addr_ack: got %b expected 0", a0); end
    q_rd_exp.push_back(8'h2A);
    q_rd_exp.push_back(8'hBC);
    read_byte(1'b0, b);
    checks++;
    if (b !== q_rd_exp[0]) begin failures++; $display("FAIL read_byte0: got %h expected %h", b, q_rd_exp[0]); end
    void'(q_rd_exp.pop_front());
    read_byte(1'b1, b);
    checks++;
    if (b !== q_rd_exp[0]) begin failures++; $display("FAIL read_byte1: got %h expected %h", b, q_rd_exp[0]); end
    void'(q_rd_exp.pop_front());
    repeat (5) @(negedge clk);
    checks++;
    if (sda_oe !== 1'b0) begin failures++; $display("FAIL read_release_after_nack: got %b expected 0", sda_oe); end
    i2c_stop();
    rd_mode = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL read_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [4:0] acks;
    logic       a;
    logic [7:0] bytes_v [5];
    int         val0;
    bytes_v = '{8'hC0, 8'h01, 8'h23, 8'h04, 8'h56};
    val0 = valid_cnt;
    i2c_start();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) q_exp.push_back('{pd: 2'd0, code: 12'h123});
      if (i == 4) q_exp.push_back('{pd: 2'd0, code: 12'h456});
      write_byte(bytes_v[i], a);
      acks[i] = a;
    end
    i2c_stop();
    settle();
    checks++;
    if (acks !== 5'b00000) begin failures++; $display("FAIL b2b_acks: got %b expected 00000", acks); end
    checks++;
    if (valid_cnt - val0 != 2) begin failures++; $display("FAIL b2b_valid_cnt: got %0d expected 2", valid_cnt - val0); end
    checks++;
    if (q_obs.size() != q_exp.size()) begin
      failures++; $display("FAIL b2b_sb_size: got %0d expected %0d", q_obs.size(), q_exp.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      dac_upd_t o, e;
      o = q_obs.pop_front(); e = q_exp.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_sb_update: got pd=%h code=%h expected pd=%h code=%h", o.pd, o.code, e.pd, e.code); end
    end
    q_obs.delete(); q_exp.delete();
  endtask

  task automatic test_reset_mid;
    logic a0, a1, a2;
    rd_mode = 1'b1;
    i2c_start();
    write_byte(8'hC1, a0);
    @(negedge clk);
    checks++;
    if (sda_oe !== 1'b1) begin failures++; $display("FAIL midrst_precondition_oe: got %b expected 1", sda_oe); end
    rst = 1'b1;
    #1;
    checks++;
    if (sda_oe !== 1'b0) begin failures++; $display("FAIL midrst_async_release: got %b expected 0", sda_oe); end
    @(negedge clk);
    checks++;
    if (dac_code !== 12'h000 || dac_pd !== 2'd0 || dac_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs: got code=%h pd=%h valid=%b busy=%b expected 000 0 0 0", dac_code, dac_pd, dac_valid, busy);
    end
    m_scl = 1'b1; m_sda = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    rd_mode = 1'b0;
    settle();
    i2c_start();
    write_byte(8'hC0, a0);
    write_byte(8'h07, a1);
    q_exp.push_back('{pd: 2'd0, code: 12'h789});
    write_byte(8'h89, a2);
    i2c_stop();
    settle();
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL midrst_after_acks: got %b expected 000", {a0, a1, a2}); end
    checks++;
    if (q_obs.size() != q_exp.size()) begin
      failures++; $display("FAIL midrst_sb_size: got %0d expected %0d", q_obs.size(), q_exp.size());
    end
    while (q_obs.size() > 0 && q_exp.size() > 0) begin
      dac_upd_t o, e;
      o = q_obs.pop_front(); e = q_exp.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL midrst_sb_update: got pd=%h code=%h expected pd=%h code=%h", o.pd, o.code, e.pd, e.code); end
    end
    q_obs.delete(); q_exp.delete();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_addr_mismatch();
    test_bad_cmd();
    test_read();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
